// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller sitting between the PC register and the instruction memory
// port. It samples the current PC, runs a req/ack read on the instruction memory and keeps
// the returned word in a one-entry IF/ID buffer until decode takes it. It also drives the
// PC register's stall input, so the PC only moves when an instruction is consumed or the
// pipeline is redirected.
//
// Ports
//   clk          in   clock, rising-edge
//   rst          in   asynchronous, active-high reset
//   pc_in        in   current PC from the PC register
//   fetch_en     in   permits a new fetch to be issued from idle
//   flush        in   redirect: drop in-flight and held instruction
//   imem_req     out  read request (registered, held until ack)
//   imem_addr    out  read address (registered, stable while requesting)
//   imem_ack     in   read completion, imem_rdata valid in the same cycle
//   imem_rdata   in   instruction word
//   id_ready     in   decode accepts the held instruction this cycle
//   id_valid     out  held instruction valid (registered)
//   id_instr     out  held instruction (registered)
//   id_pc        out  address of the held instruction (registered)
//   pc_stall     out  stall input of the PC register (combinational)
//
// Optional feature, enabled by defining IF_FETCH_PERF_EN:
//   perf_fetch_cnt  out  instructions accepted by decode (wraps at 2^32)
//   perf_wait_cnt   out  cycles with a request outstanding and no ack (wraps at 2^32)
// With the macro undefined these ports and counters do not exist.
// ---------------------------------------------------------------------------------------------

module if_fetch_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              pc_stall
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    // StDrop: a request was flushed while still outstanding. The memory cannot have the
    // request withdrawn, so we keep imem_req up until the ack arrives and throw the data away.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDrop
    } state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;

        case (state_q)
            StIdle: begin
                if (fetch_en && !flush) begin
                    req_d   = 1'b1;
                    addr_d  = pc_in;
                    state_d = StReq;
                end
            end

            StReq: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (flush) begin
                        // Redirect wins over the returning word.
                        state_d = StIdle;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = addr_q;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end else if (flush) begin
                    state_d = StDrop;
                end
            end

            StDrop: begin
                // Further flushes carry no extra meaning here; only the ack matters.
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end

            StHold: begin
                // Either consumption or a redirect empties the buffer. id_instr/id_pc keep
                // their stale contents; only the valid bit clears.
                if (flush || id_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // The PC register loads a new value exactly when the held instruction is taken or on a
    // redirect (in which case it loads the redirect target).
    always_comb begin
        pc_stall = !(((state_q == StHold) && id_ready) || flush);
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = valid_q;
    assign id_instr  = instr_q;
    assign id_pc     = pc_q;

`ifdef IF_FETCH_PERF_EN
    // -----------------------------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------------------------
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        // Only a genuine consumption counts; a flushed instruction was never delivered.
        if ((state_q == StHold) && id_ready && !flush) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        // Counts wait cycles of dropped requests too, since the memory is still busy.
        if (req_q && !imem_ack) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// Bench for if_fetch_ctrl. A transaction-level model (outstanding request, discard flag,
// one-entry buffer) tracks the expected outputs and is compared every cycle on the falling
// edge; directed sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------------------------

module tb_if_fetch_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              fetch_en;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              id_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              pc_stall;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_wait_cnt;
    logic [31:0]       f0, w0;
    logic [31:0]       m_fcnt, m_wcnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .pc_stall  (pc_stall)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt (perf_wait_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ reference model
    logic              m_req, m_discard, m_valid;
    logic [ADDR_W-1:0] m_addr, m_pc;
    logic [DATA_W-1:0] m_instr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req     <= 1'b0;
            m_discard <= 1'b0;
            m_valid   <= 1'b0;
            m_addr    <= '0;
            m_pc      <= '0;
            m_instr   <= '0;
`ifdef IF_FETCH_PERF_EN
            m_fcnt    <= '0;
            m_wcnt    <= '0;
`endif
        end else begin
`ifdef IF_FETCH_PERF_EN
            if (m_req && !imem_ack) m_wcnt <= m_wcnt + 1;
            if (m_valid && id_ready && !flush) m_fcnt <= m_fcnt + 1;
`endif
            if (m_valid) begin
                if (flush || id_ready) m_valid <= 1'b0;
            end else if (m_req) begin
                if (imem_ack) begin
                    m_req     <= 1'b0;
                    m_discard <= 1'b0;
                    if (!m_discard && !flush) begin
                        m_valid <= 1'b1;
                        m_instr <= imem_rdata;
                        m_pc    <= m_addr;
                    end
                end else if (flush) begin
                    m_discard <= 1'b1;
                end
            end else if (fetch_en && !flush) begin
                m_req  <= 1'b1;
                m_addr <= pc_in;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_req",   imem_req,  m_req);
        chk("cmp_addr",  imem_addr, m_addr);
        chk("cmp_valid", id_valid,  m_valid);
        chk("cmp_instr", id_instr,  m_instr);
        chk("cmp_pc",    id_pc,     m_pc);
        chk("cmp_stall", pc_stall,  !((m_valid && id_ready) || flush));
`ifdef IF_FETCH_PERF_EN
        chk("cmp_pfetch", perf_fetch_cnt, m_fcnt);
        chk("cmp_pwait",  perf_wait_cnt,  m_wcnt);
`endif
    end

    // ------------------------------------------------------------------ stimulus
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pc_in = '0; fetch_en = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", pc_stall, 1'b1);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_instr", id_instr, 32'h0);

        // Zero-wait fetch
        nxt(); pc_in = 32'h0040_0000; fetch_en = 1'b1; id_ready = 1'b1;
        @(negedge clk); chk("zw_c0_stall", pc_stall, 1'b1);
        nxt(); fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        chk("zw_c1_req", imem_req, 1'b1);
        chk("zw_c1_addr", imem_addr, 32'h0040_0000);
        chk("zw_c1_stall", pc_stall, 1'b1);
        nxt(); imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        chk("zw_c2_valid", id_valid, 1'b1);
        chk("zw_c2_instr", id_instr, 32'h2008_0005);
        chk("zw_c2_pc", id_pc, 32'h0040_0000);
        chk("zw_c2_stall", pc_stall, 1'b0);
        nxt();
        @(negedge clk);
        chk("zw_c3_valid", id_valid, 1'b0);
        chk("zw_c3_stall", pc_stall, 1'b1);

        // Wait states followed by backpressure
`ifdef IF_FETCH_PERF_EN
        f0 = perf_fetch_cnt; w0 = perf_wait_cnt;
`endif
        pc_in = 32'h0040_0004; fetch_en = 1'b1; id_ready = 1'b0;
        nxt(); fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack   = (i == 3);
            imem_rdata = (i == 3) ? 32'h3C01_1001 : 32'h0;
            @(negedge clk);
            chk("ws_req", imem_req, 1'b1);
            chk("ws_addr", imem_addr, 32'h0040_0004);
            nxt();
        end
        imem_ack = 1'b0; imem_rdata = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_instr", id_instr, 32'h3C01_1001);
            chk("bp_valid", id_valid, 1'b1);
            chk("bp_stall", pc_stall, 1'b1);
            chk("bp_req", imem_req, 1'b0);
            nxt();
        end
        id_ready = 1'b1;
        @(negedge clk); chk("bp_accept_stall", pc_stall, 1'b0);
        nxt();
        @(negedge clk); chk("bp_after_valid", id_valid, 1'b0);
`ifdef IF_FETCH_PERF_EN
        chk("perf_wait_delta", perf_wait_cnt - w0, 32'd3);
        chk("perf_fetch_delta", perf_fetch_cnt - f0, 32'd1);
`endif

        // Flush in REQ on the 2nd wait cycle, ack two cycles later
        pc_in = 32'h0040_0008; fetch_en = 1'b1;
        nxt();
        @(negedge clk); chk("fr_addr", imem_addr, 32'h0040_0008);
        nxt(); flush = 1'b1; pc_in = 32'h0040_0100;
        @(negedge clk); chk("fr_flush_stall", pc_stall, 1'b0);
        nxt(); // DROP; a repeated flush is ignored
        @(negedge clk); chk("fr_drop_req", imem_req, 1'b1);
        nxt(); flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("fr_drop_ack_req", imem_req, 1'b1);
        nxt(); imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        chk("fr_idle_valid", id_valid, 1'b0);
        chk("fr_idle_req", imem_req, 1'b0);
        nxt();
        @(negedge clk);
        chk("fr_redir_addr", imem_addr, 32'h0040_0100);
        chk("fr_redir_req", imem_req, 1'b1);

        // Flush coincident with ack
        nxt(); fetch_en = 1'b0; imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'h1111_1111;
        @(negedge clk); chk("fa_stall", pc_stall, 1'b0);
        nxt(); imem_ack = 1'b0; flush = 1'b0; imem_rdata = '0;
        @(negedge clk);
        chk("fa_valid", id_valid, 1'b0);
        chk("fa_req", imem_req, 1'b0);

        // Flush in IDLE blocks issue
        fetch_en = 1'b1; flush = 1'b1;
        nxt(); fetch_en = 1'b0; flush = 1'b0;
        @(negedge clk); chk("fi_req", imem_req, 1'b0);

        // Flush in HOLD
        pc_in = 32'h0040_0200; fetch_en = 1'b1; id_ready = 1'b0;
        nxt(); fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        nxt(); imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk); chk("fh_valid", id_valid, 1'b1);
        nxt(); flush = 1'b1; id_ready = 1'b1;
        @(negedge clk); chk("fh_stall", pc_stall, 1'b0);
        nxt(); flush = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        chk("fh_after_valid", id_valid, 1'b0);
        chk("fh_stale_instr", id_instr, 32'h2222_2222);
        chk("fh_stale_pc", id_pc, 32'h0040_0200);

        // Asynchronous reset in the middle of a request
        pc_in = 32'h0040_0300; fetch_en = 1'b1;
        nxt(); fetch_en = 1'b0;
        #1;
        chk("ar_pre_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_req", imem_req, 1'b0);
        chk("ar_valid", id_valid, 1'b0);
        chk("ar_instr", id_instr, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        #5 rst = 1'b0;
        nxt();
        @(negedge clk);
        chk("ar_post_stall", pc_stall, 1'b1);
        chk("ar_post_req", imem_req, 1'b0);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
